// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice: EX/MEM occupancy encoding
// and control-bundle width.
package mips_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    // Control bundle order: {RegWrite, MemToReg, MemWrite, MemRead}
    localparam int CTRL_W = 4;

endpackage

// File: rtl/exmem_perf_cnt.sv
// Saturating event counter used by the EX/MEM stage when EXMEM_PERF_CNT_EN
// is defined; holds at all-ones instead of wrapping.
module exmem_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built as a two-entry skid buffer (main + skid).
// Optional stall/flush performance counters are enabled by EXMEM_PERF_CNT_EN.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_E,
    output logic                  ready_E,
    input  logic                  flush,
    input  logic                  RegWrite_E,
    input  logic                  MemToReg_E,
    input  logic                  MemWrite_E,
    input  logic                  MemRead_E,
    input  logic [DATA_W-1:0]     ALUout_E,
    input  logic [DATA_W-1:0]     WriteData_E,
    input  logic [REG_ADDR_W-1:0] WriteReg_E,
    output logic                  valid_M,
    input  logic                  ready_M,
    output logic                  RegWrite_M,
    output logic                  MemToReg_M,
    output logic                  MemWrite_M,
    output logic                  MemRead_M,
    output logic [DATA_W-1:0]     ALUout_M,
    output logic [DATA_W-1:0]     WriteData_M,
    output logic [REG_ADDR_W-1:0] WriteReg_M
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    occ_state_e state_q, state_d;
    logic       ready_q;
    logic       accept, consume;
    logic       load_main_in, load_main_skid, load_skid;

    logic [CTRL_W-1:0]     ctrl_E;
    logic [CTRL_W-1:0]     main_ctrl, skid_ctrl;
    logic [DATA_W-1:0]     main_alu, skid_alu;
    logic [DATA_W-1:0]     main_wd, skid_wd;
    logic [REG_ADDR_W-1:0] main_wr, skid_wr;

    assign ctrl_E  = {RegWrite_E, MemToReg_E, MemWrite_E, MemRead_E};
    assign ready_E = ready_q;
    assign accept  = valid_E && ready_q;
    assign consume = valid_M && ready_M;

    // ready_E is registered from the next state so it never depends on ready_M
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !consume)      state_d = FULL;
                    else if (!accept && consume) state_d = EMPTY;
                end
                FULL: if (consume) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        valid_M        = (state_q == ONE) || (state_q == FULL);
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            load_main_in   = ((state_q == EMPTY) && accept) ||
                             ((state_q == ONE) && accept && consume);
            load_skid      = (state_q == ONE) && accept && !consume;
            load_main_skid = (state_q == FULL) && consume;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl <= '0;
            main_alu  <= '0;
            main_wd   <= '0;
            main_wr   <= '0;
            skid_ctrl <= '0;
            skid_alu  <= '0;
            skid_wd   <= '0;
            skid_wr   <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl <= ctrl_E;
                main_alu  <= ALUout_E;
                main_wd   <= WriteData_E;
                main_wr   <= WriteReg_E;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_alu  <= skid_alu;
                main_wd   <= skid_wd;
                main_wr   <= skid_wr;
            end
            if (load_skid) begin
                skid_ctrl <= ctrl_E;
                skid_alu  <= ALUout_E;
                skid_wd   <= WriteData_E;
                skid_wr   <= WriteReg_E;
            end
        end
    end

    // Bubbles must never write the register file or memory
    assign RegWrite_M  = main_ctrl[3] & valid_M;
    assign MemToReg_M  = main_ctrl[2] & valid_M;
    assign MemWrite_M  = main_ctrl[1] & valid_M;
    assign MemRead_M   = main_ctrl[0] & valid_M;
    assign ALUout_M    = main_alu;
    assign WriteData_M = main_wd;
    assign WriteReg_M  = main_wr;

`ifdef EXMEM_PERF_CNT_EN
    exmem_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (valid_M && !ready_M),
        .cnt   (stall_cnt)
    );

    exmem_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .cnt   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: queue scoreboard with an independent
// occupancy model; counter checks compiled in with EXMEM_PERF_CNT_EN.
module tb_ex_mem_stage;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_E, ready_E, flush;
    logic          RegWrite_E, MemToReg_E, MemWrite_E, MemRead_E;
    logic [DW-1:0] ALUout_E, WriteData_E;
    logic [AW-1:0] WriteReg_E;
    logic          valid_M, ready_M;
    logic          RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M;
    logic [DW-1:0] ALUout_M, WriteData_M;
    logic [AW-1:0] WriteReg_M;
`ifdef EXMEM_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
    int            stall_m, flush_m;
`endif

    typedef struct packed {
        logic [3:0]    ctrl;
        logic [DW-1:0] alu;
        logic [DW-1:0] wd;
        logic [AW-1:0] wr;
    } ent_t;

    ent_t q[$];
    bit   ready_en;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_E     (valid_E),
        .ready_E     (ready_E),
        .flush       (flush),
        .RegWrite_E  (RegWrite_E),
        .MemToReg_E  (MemToReg_E),
        .MemWrite_E  (MemWrite_E),
        .MemRead_E   (MemRead_E),
        .ALUout_E    (ALUout_E),
        .WriteData_E (WriteData_E),
        .WriteReg_E  (WriteReg_E),
        .valid_M     (valid_M),
        .ready_M     (ready_M),
        .RegWrite_M  (RegWrite_M),
        .MemToReg_M  (MemToReg_M),
        .MemWrite_M  (MemWrite_M),
        .MemRead_M   (MemRead_M),
        .ALUout_M    (ALUout_M),
        .WriteData_M (WriteData_M),
        .WriteReg_M  (WriteReg_M)
`ifdef EXMEM_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] a, input logic [3:0] c);
        valid_E     = v;
        ALUout_E    = a;
        WriteData_E = ~a;
        WriteReg_E  = a[AW-1:0];
        {RegWrite_E, MemToReg_E, MemWrite_E, MemRead_E} = c;
    endtask

    // Called just after a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        bit   exp_v, exp_r, acc, con;
        ent_t e;
        #1;
        exp_v = (q.size() > 0);
        exp_r = ready_en && (q.size() < 2);
        chk("valid_M", valid_M, exp_v);
        chk("ready_E", ready_E, exp_r);
        if (!exp_v) begin
            chk("bubble_ctrl", {RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M}, 4'b0);
        end else begin
            chk("ctrl_M", {RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M}, q[0].ctrl);
            chk("ALUout_M", ALUout_M, q[0].alu);
            chk("WriteData_M", WriteData_M, q[0].wd);
            chk("WriteReg_M", WriteReg_M, q[0].wr);
        end
`ifdef EXMEM_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, stall_m);
        chk("flush_cnt", flush_cnt, flush_m);
        if (exp_v && !ready_M && stall_m != CMAX) stall_m++;
        if (flush && flush_m != CMAX) flush_m++;
`endif
        acc = valid_E && exp_r;
        con = exp_v && ready_M;
        if (con) void'(q.pop_front());
        if (flush) begin
            q.delete();
        end else if (acc) begin
            e.ctrl = {RegWrite_E, MemToReg_E, MemWrite_E, MemRead_E};
            e.alu  = ALUout_E;
            e.wd   = WriteData_E;
            e.wr   = WriteReg_E;
            q.push_back(e);
        end
        @(posedge clk);
        ready_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid_M", valid_M, 1'b0);
        chk("async_rst_ready_E", ready_E, 1'b0);
        chk("async_rst_ALUout_M", ALUout_M, '0);
        chk("async_rst_ctrl", {RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M}, 4'b0);
        #2 rst_n = 1'b1;
        q.delete();
        ready_en = 1'b0;
`ifdef EXMEM_PERF_CNT_EN
        stall_m = 0;
        flush_m = 0;
`endif
        @(posedge clk);
        ready_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        ready_M = 1'b0;
        ready_en = 1'b0;
        drive(1'b0, '0, 4'b0);
`ifdef EXMEM_PERF_CNT_EN
        stall_m = 0;
        flush_m = 0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid_M", valid_M, 1'b0);
        chk("reset_ready_E", ready_E, 1'b0);
        chk("reset_ALUout_M", ALUout_M, '0);
        chk("reset_WriteReg_M", WriteReg_M, '0);
        rst_n = 1'b1;
        tick();

        // Single entry, no backpressure
        ready_M = 1'b1;
        drive(1'b1, 32'h0000_00AA, 4'b1000);
        tick();
        drive(1'b0, '0, 4'b0);
        chk("lat1_valid_M", valid_M, 1'b1);
        chk("lat1_ALUout_M", ALUout_M, 32'hAA);
        tick();
        tick();

        // Backpressure: 1 and 2 accepted, 3 waits until MEM drains
        ready_M = 1'b0;
        drive(1'b1, 32'h1, 4'b1001);
        tick();
        drive(1'b1, 32'h2, 4'b0110);
        tick();
        drive(1'b1, 32'h3, 4'b1100);
        chk("full_ready_E", ready_E, 1'b0);
        tick();
        tick();
        ready_M = 1'b1;
        tick();
        tick();
        drive(1'b0, '0, 4'b0);
        repeat (4) tick();

        // Fill, then flush with an incoming entry
        ready_M = 1'b0;
        drive(1'b1, 32'h11, 4'b1111);
        tick();
        drive(1'b1, 32'h22, 4'b1010);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'hDEAD, 4'b1111);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 4'b0);
        chk("flush_valid_M", valid_M, 1'b0);
        chk("flush_RegWrite_M", RegWrite_M, 1'b0);
        ready_M = 1'b1;
        repeat (3) tick();

        // Invalid EX slot with RegWrite set must stay a bubble
        drive(1'b0, 32'h55, 4'b1000);
        repeat (3) tick();
        chk("bubble_RegWrite_M", RegWrite_M, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
            ready_M = 1'($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0;

        // Asynchronous reset while holding one entry
        ready_M = 1'b0;
        drive(1'b1, 32'h77, 4'b1011);
        tick();
        drive(1'b0, '0, 4'b0);
        chk("one_before_rst", valid_M, 1'b1);
        reset_pulse();
        tick();
        tick();

`ifdef EXMEM_PERF_CNT_EN
        // Stall counter saturation
        ready_M = 1'b0;
        drive(1'b1, 32'h99, 4'b1000);
        tick();
        drive(1'b0, '0, 4'b0);
        repeat (20) tick();
        chk("stall_cnt_sat", stall_cnt, 4'hF);
`endif

        ready_M = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
- REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the ALU result and store data.
- REQ-002 The block SHALL have parameter REG_ADDR_W, default 5, giving the width of the destination register index.
- REQ-003 The block SHALL have parameter CNT_W, default 16, giving the performance counter width; it is used only when EXMEM_PERF_CNT_EN is defined.
- REQ-004 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
- REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
- REQ-006 Port valid_E: input, 1 bit, EX presents a valid instruction.
- REQ-007 Port ready_E: output, 1 bit, the stage can accept from EX this cycle.
- REQ-008 Port flush: input, 1 bit, discard all held and incoming instructions.
- REQ-009 Ports RegWrite_E, MemToReg_E, MemWrite_E and MemRead_E: inputs, 1 bit each, EX control bits.
- REQ-010 Ports ALUout_E and WriteData_E: inputs, DATA_W each, EX data.
- REQ-011 Port WriteReg_E: input, REG_ADDR_W, destination register.
- REQ-012 Port valid_M: output, 1 bit, MEM-side instruction is valid.
- REQ-013 Port ready_M: input, 1 bit, MEM consumes this cycle.
- REQ-014 Ports RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M, ALUout_M, WriteData_M and WriteReg_M: outputs, widths matching their _E counterparts.
- REQ-015 Ports stall_cnt and flush_cnt: outputs, CNT_W each; present only with EXMEM_PERF_CNT_EN.

Function
- REQ-016 The block SHALL be a two-entry skid buffer with a main register driving the _M outputs and one skid register.
- REQ-017 Occupancy states SHALL be EMPTY, ONE and FULL; ready_E SHALL be 1 in EMPTY and ONE and 0 in FULL, and SHALL be driven by a register.
- REQ-018 An accept SHALL be valid_E&&ready_E; a consume SHALL be valid_M&&ready_M; valid_M SHALL be 1 exactly in ONE and FULL.
- REQ-019 State transitions SHALL be:
  - EMPTY+accept->ONE;
  - ONE+accept+consume->ONE, main loaded with the new entry;
  - ONE+accept, no consume->FULL, new entry into skid;
  - ONE+consume, no accept->EMPTY;
  - FULL+consume->ONE, skid moved to main;
  - all other cases hold state and contents.
- REQ-020 Latency from accept to valid_M SHALL be one cycle when the stage is not backpressured.
- REQ-021 Ordering SHALL be strict FIFO and no accepted entry SHALL be lost or duplicated.
- REQ-022 flush SHALL take priority: the next state SHALL be EMPTY regardless of accept or consume, and an entry accepted in the flush cycle SHALL be dropped.
- REQ-023 While valid_M=0, RegWrite_M, MemWrite_M, MemRead_M and MemToReg_M SHALL read 0, so that bubbles never write; the data outputs are don't-care.
- REQ-024 Output contents SHALL remain stable while valid_M&&!ready_M.

Reset
- REQ-025 On rst_n=0 the block SHALL asynchronously enter EMPTY with ready_E=0, all _M outputs 0 and the counters 0.
- REQ-026 ready_E SHALL rise on the first clk edge after reset release.
- REQ-027 A reset asserted mid-transfer SHALL discard all entries.

Configuration
- REQ-028 With EXMEM_PERF_CNT_EN defined, stall_cnt SHALL increment on each cycle with valid_M&&!ready_M and flush_cnt SHALL increment on each flush cycle; both SHALL saturate at all-ones.
- REQ-029 Without EXMEM_PERF_CNT_EN, the counter ports and logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
- REQ-030 Shared package mips_pkg SHALL hold the occupancy-state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and the control-bundle width constant (4).
- REQ-031 A sub-module exmem_perf_cnt, a saturating counter of width CNT_W, SHALL be instantiated twice under the macro.

Verification
- REQ-032 Scenario: reset, then valid_E=1 with ALUout_E=0x0000_00AA and ready_M=1 -> valid_M=1 and ALUout_M=0xAA one cycle later.
- REQ-033 Scenario: ready_M=0 while three entries (0x1, 0x2, 0x3) are offered back-to-back -> 0x1 and 0x2 are accepted, ready_E=0 on the third; on releasing ready_M, the outputs are 0x1, 0x2 and 0x3 in order.
- REQ-034 Scenario: FULL, then flush=1 with valid_E=1 -> the next cycle is EMPTY with valid_M=0 and RegWrite_M=0, and the incoming entry never appears.
- REQ-035 Scenario: valid_E=0 while RegWrite_E=1 -> RegWrite_M stays 0.
- REQ-036 Scenario: rst_n pulsed low for 3 ns between clk edges while in ONE -> outputs go to 0 immediately, without waiting for a clk edge.
- REQ-037 Scenario (with EXMEM_PERF_CNT_EN, CNT_W=4): 20 backpressure cycles -> stall_cnt=15, saturated.
